// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port arbiter with lock for one single-port synchronous RAM
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin contention; the default build is fixed priority to port 0.
module ram_arbiter #(
    parameter int data_length = 32,
    parameter int mem_length  = 32,
    localparam int AW = (mem_length > 1) ? $clog2(mem_length) : 1
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   m0_valid,
    output logic                   m0_ready,
    input  logic                   m0_we,
    input  logic                   m0_lock,
    input  logic [AW-1:0]          m0_addr,
    input  logic [data_length-1:0] m0_wdata,
    output logic                   m0_rvalid,
    output logic [data_length-1:0] m0_rdata,

    input  logic                   m1_valid,
    output logic                   m1_ready,
    input  logic                   m1_we,
    input  logic                   m1_lock,
    input  logic [AW-1:0]          m1_addr,
    input  logic [data_length-1:0] m1_wdata,
    output logic                   m1_rvalid,
    output logic [data_length-1:0] m1_rdata,

    output logic                   ram_we,
    output logic [AW-1:0]          ram_address,
    output logic [data_length-1:0] ram_write_data,
    input  logic [data_length-1:0] ram_return_data
);

    typedef enum logic [1:0] {
        OPEN  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   rvalid0_q, rvalid0_d;
    logic   rvalid1_q, rvalid1_d;
    logic   gnt0, gnt1;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // Port that won the most recent transfer; contention goes to the other one.
    logic   last_grant_q, last_grant_d;
`endif

    // Nothing is granted while reset is held, so the RAM sees an idle bus.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case (state_q)
                OPEN: begin
                    if (m0_valid && m1_valid) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
                        gnt0 = last_grant_q;
                        gnt1 = !last_grant_q;
`else
                        gnt0 = 1'b1;
`endif
                    end else begin
                        gnt0 = m0_valid;
                        gnt1 = m1_valid;
                    end
                end
                LOCK0:   gnt0 = m0_valid;
                LOCK1:   gnt1 = m1_valid;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OPEN: begin
                if (gnt0 && m0_lock)
                    state_d = LOCK0;
                else if (gnt1 && m1_lock)
                    state_d = LOCK1;
            end
            // An idle owner releases the lock so the other port cannot starve.
            LOCK0: if (!m0_valid || !m0_lock) state_d = OPEN;
            LOCK1: if (!m1_valid || !m1_lock) state_d = OPEN;
            default: state_d = OPEN;
        endcase
    end

    assign rvalid0_d = gnt0 && !m0_we;
    assign rvalid1_d = gnt1 && !m1_we;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt0)
            last_grant_d = 1'b0;
        else if (gnt1)
            last_grant_d = 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= OPEN;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    always_comb begin
        ram_we         = 1'b0;
        ram_address    = '0;
        ram_write_data = '0;
        if (gnt0) begin
            ram_we         = m0_we;
            ram_address    = m0_addr;
            ram_write_data = m0_wdata;
        end else if (gnt1) begin
            ram_we         = m1_we;
            ram_address    = m1_addr;
            ram_write_data = m1_wdata;
        end
    end

    assign m0_ready  = gnt0;
    assign m1_ready  = gnt1;
    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    assign m0_rdata  = ram_return_data;
    assign m1_rdata  = ram_return_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized and directed checks of ram_arbiter against a transaction-level model
module tb_ram_arbiter;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_valid = 0, m0_we = 0, m0_lock = 0;
    logic [4:0]  m0_addr = '0;
    logic [31:0] m0_wdata = '0;
    logic        m1_valid = 0, m1_we = 0, m1_lock = 0;
    logic [4:0]  m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic        m0_ready, m0_rvalid, m1_ready, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_we;
    logic [4:0]  ram_address;
    logic [31:0] ram_write_data;
    logic [31:0] ram_return_data;

    ram_arbiter #(.data_length(32), .mem_length(32)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_lock(m0_lock),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_lock(m1_lock),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_we(ram_we), .ram_address(ram_address), .ram_write_data(ram_write_data),
        .ram_return_data(ram_return_data)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [32];
    logic        init_mem = 1'b0;
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 32; i++) ram[i] <= 32'(i) * 32'h01010101 + 32'h7;
        end else if (ram_we) begin
            ram[ram_address] <= ram_write_data;
        end else begin
            ram_return_data <= ram[ram_address];
        end
    end

    // Reference: owner (-1 when unlocked), last winner, memory image, expected responses.
    int          owner = -1;
    int          last = 1;
    logic [31:0] refmem [32];
    bit          erv0 = 0, erv1 = 0;
    logic [31:0] erd0 = '0, erd1 = '0;
    bit          obs_rdy0, obs_rdy1, obs_rv0;
    logic [31:0] obs_rd0;

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_grant();
        if (rst) return -1;
        if (owner == 0) return m0_valid ? 0 : -1;
        if (owner == 1) return m1_valid ? 1 : -1;
        if (m0_valid && m1_valid) return RR ? ((last == 1) ? 0 : 1) : 0;
        if (m0_valid) return 0;
        if (m1_valid) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        owner = -1;
        last  = 1;
        erv0  = 0;
        erv1  = 0;
    endtask

    task automatic step(input bit v0, input bit w0, input bit l0, input int a0, input logic [31:0] d0,
                        input bit v1, input bit w1, input bit l1, input int a1, input logic [31:0] d1);
        int          eg;
        bit          ewe, lk;
        int          ea;
        logic [31:0] ed;
        m0_valid = v0; m0_we = w0; m0_lock = l0; m0_addr = a0[4:0]; m0_wdata = d0;
        m1_valid = v1; m1_we = w1; m1_lock = l1; m1_addr = a1[4:0]; m1_wdata = d1;
        @(negedge clk);
        eg  = exp_grant();
        ewe = (eg == 0) ? w0 : (eg == 1) ? w1 : 1'b0;
        ea  = (eg == 0) ? a0 : (eg == 1) ? a1 : 0;
        ed  = (eg == 0) ? d0 : (eg == 1) ? d1 : 32'h0;
        lk  = (eg == 0) ? l0 : (eg == 1) ? l1 : 1'b0;
        check("ready0", 32'(m0_ready), 32'(eg == 0));
        check("ready1", 32'(m1_ready), 32'(eg == 1));
        check("ram_we", 32'(ram_we), 32'(ewe));
        check("ram_address", 32'(ram_address), 32'(ea));
        check("ram_write_data", ram_write_data, ed);
        check("rvalid0", 32'(m0_rvalid), 32'(erv0));
        check("rvalid1", 32'(m1_rvalid), 32'(erv1));
        if (erv0) check("rdata0", m0_rdata, erd0);
        if (erv1) check("rdata1", m1_rdata, erd1);
        obs_rdy0 = m0_ready;
        obs_rdy1 = m1_ready;
        obs_rv0  = m0_rvalid;
        obs_rd0  = m0_rdata;
        @(posedge clk);
        erv0 = 0;
        erv1 = 0;
        if (eg >= 0) begin
            last = eg;
            if (ewe) begin
                refmem[ea] = ed;
            end else if (eg == 0) begin
                erv0 = 1; erd0 = refmem[ea];
            end else begin
                erv1 = 1; erd1 = refmem[ea];
            end
        end
        owner = (eg >= 0 && lk) ? eg : -1;
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        m0_valid = 0;
        m1_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    int rv_count;

    initial begin
        for (int i = 0; i < 32; i++) refmem[i] = 32'(i) * 32'h01010101 + 32'h7;
        init_mem = 1'b1;
        @(posedge clk);
        #1;
        init_mem = 1'b0;
        @(negedge clk);
        check("reset_ready0", 32'(m0_ready), 32'h0);
        check("reset_ready1", 32'(m1_ready), 32'h0);
        check("reset_rvalid0", 32'(m0_rvalid), 32'h0);
        check("reset_ram_we", 32'(ram_we), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();

        // Reset in the middle of a port-1 read.
        step(0, 0, 0, 0, 0, 1, 0, 0, 7, 0);
        rst = 1'b1;
        #1;
        check("rst_rvalid1", 32'(m1_rvalid), 32'h0);
        check("rst_rvalid0", 32'(m0_rvalid), 32'h0);
        check("rst_ready1", 32'(m1_ready), 32'h0);
        check("rst_ready0", 32'(m0_ready), 32'h0);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        check("rst_ram_address", 32'(ram_address), 32'h0);
        check("rst_ram_write_data", ram_write_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(0, 0, 0, 0, 0, 1, 0, 0, 4, 0);
        check("post_rst_p1_grant", 32'(obs_rdy1), 32'h1);
        idle();

        // Write then immediate readback on port 0.
        step(1, 1, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        step(1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        idle();
        check("wr_rd_rvalid0", 32'(obs_rv0), 32'h1);
        check("wr_rd_rdata0", obs_rd0, 32'hDEADBEEF);

        // Contention from a fresh reset.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 1, 0, 1, 0, 0, 2, 0);
            check("contention_grant0", 32'(obs_rdy0), RR ? 32'(i % 2 == 0) : 32'h1);
        end
        idle();
        idle();

        // Port 1 locked burst of three writes while port 0 waits.
        step(1, 0, 0, 9, 0, 0, 0, 0, 0, 0);
        step(RR, 0, 0, 9, 0, 1, 1, 1, 10, 32'hA0);
        check("lock_w1_p1", 32'(obs_rdy1), 32'h1);
        step(1, 0, 0, 9, 0, 1, 1, 1, 11, 32'hA1);
        check("lock_w2_p0_blocked", 32'(obs_rdy0), 32'h0);
        step(1, 0, 0, 9, 0, 1, 1, 0, 12, 32'hA2);
        check("lock_w3_p0_blocked", 32'(obs_rdy0), 32'h0);
        step(1, 0, 0, 9, 0, 1, 1, 0, 13, 32'hA3);
        check("lock_release_p0", 32'(obs_rdy0), 32'h1);
        idle();

        // Locked owner goes idle: the lock is dropped one cycle later.
        step(0, 0, 0, 0, 0, 1, 0, 1, 3, 0);
        step(1, 0, 0, 6, 0, 0, 0, 0, 0, 0);
        check("abandon_p0_wait", 32'(obs_rdy0), 32'h0);
        step(1, 0, 0, 6, 0, 0, 0, 0, 0, 0);
        check("abandon_p0_grant", 32'(obs_rdy0), 32'h1);
        idle();

        // Read, write, read on one address.
        rv_count = 0;
        step(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 3, 32'h11, 0, 0, 0, 0, 0);
        rv_count += int'(obs_rv0);
        step(1, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        rv_count += int'(obs_rv0);
        idle();
        rv_count += int'(obs_rv0);
        check("mixed_last_rdata", obs_rd0, 32'h11);
        idle();
        rv_count += int'(obs_rv0);
        check("mixed_rvalid_count", 32'(rv_count), 32'h2);

        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) apply_reset();
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 31)), $urandom);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares one single-port synchronous RAM (write on clock edge when `we`=1, registered read data one cycle after a `we`=0 access) between a CPU data port (port 0) and a secondary master such as a loader or DMA (port 1). The block issues at most one RAM access per cycle and can issue back-to-back. It returns read data to the requester that issued the read, and supports a lock so one master can own the RAM for a burst. It sits between the masters and the RAM instance and drives the RAM's `we`, `address` and `write_data` pins.

## Interface
- `data_length`, default 32: RAM data width.
- `mem_length`, default 32: RAM depth in words. Address width is `$clog2(mem_length)`, written AW below.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `m0_valid` in 1: port 0 request valid.
- `m0_ready` out 1: port 0 request accepted this cycle.
- `m0_we` in 1: port 0 request is a write (1) or a read (0).
- `m0_lock` in 1: hold ownership after this transfer.
- `m0_addr` in AW: port 0 address.
- `m0_wdata` in `data_length`: port 0 write data.
- `m0_rvalid` out 1: port 0 read data valid.
- `m0_rdata` out `data_length`: port 0 read data.
- `m1_*`: same set for port 1.
- `ram_we` out 1: to RAM `we`.
- `ram_address` out AW: to RAM `address`.
- `ram_write_data` out `data_length`: to RAM `write_data`.
- `ram_return_data` in `data_length`: from RAM `return_data`.

## Operation
- **Transfer:** a transfer on port N occurs in a cycle where `mN_valid`=1 and `mN_ready`=1.
- **Ready rule:** `mN_ready` is combinational from the valids, lock state and arbitration state. At most one `mN_ready` is high per cycle. `mN_ready` is never high while `mN_valid` is low.
- **RAM drive:** the RAM pins are combinational from the winning port's `we`/`addr`/`wdata`.
- **Idle:** with no winner, `ram_we`=0, `ram_address`=0 and `ram_write_data`=0.
- **Lock FSM**, states OPEN, LOCK0, LOCK1:
  - OPEN: arbitrate between the two ports. A transfer on port N with `mN_lock`=1 moves to LOCKN.
  - LOCKN: only port N can be granted.
    - A transfer with `mN_lock`=0 returns to OPEN.
    - `mN_valid`=0 in any LOCKN cycle returns to OPEN on the next edge, so a lock cannot deadlock the other port.
- **Arbitration in OPEN:**
  - If exactly one port is valid, that port wins.
  - Contention is resolved per Configuration.
  - The `last_grant` register updates on every transfer, including transfers made in LOCKN.
- **Read response:**
  - A read transfer on port N sets a registered `mN_rvalid`=1 for exactly the next cycle.
  - `mN_rdata` is `ram_return_data` passed through combinationally.
  - Writes produce no response.
  - Back-to-back reads give back-to-back `rvalid` pulses in issue order.
- **Data hold:** `mN_rdata` is undefined when `mN_rvalid`=0.
- **Write-then-read:** a write and a following read to the same address in consecutive cycles returns the newly written data, because the RAM wrote on the earlier edge.

## Timing
- **Reset values:** state=OPEN, `last_grant`=1 (port 0 wins the first contention), `m0_rvalid`=`m1_rvalid`=0. Combinational outputs follow their rules with all valids low: both readies 0, RAM pins 0.
- **Reset mid-operation:** any pending read response is dropped and `rvalid` is 0 from reset assertion. A held lock is released.
- **Latency:**
  - Request to RAM: 0 cycles (same cycle).
  - Read response: 1 cycle after the transfer.
- **Throughput:** one transfer per cycle, sustained.
- **Starvation bound:** with round-robin compiled in and no lock, a continuously valid port waits at most 1 cycle.
- **Simultaneous events:** a lock release by port N and a port-M request in the same cycle grants M on the following cycle, not the same one.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN` defined: OPEN-state contention grants the port other than `last_grant`.
- `RAM_ARB_ROUND_ROBIN_EN` undefined: OPEN-state contention always grants port 0 (fixed priority). `last_grant` is unused.
- Lock behaviour is identical in both builds.

## Test plan
- **Reset check:** assert `rst` while `m1_valid`=1 with a read in flight -> both rvalid 0, both ready 0, RAM pins 0. After release, the first port-1-only request is granted in the same cycle.
- **Single-port write/readback:** port 0 writes 0xDEADBEEF to addr 5, then reads addr 5 in the next cycle -> `m0_rvalid`=1 one cycle after the read with `m0_rdata`=0xDEADBEEF. `m1_rvalid` stays 0.
- **Contention:** both ports hold valid reads (addr 1, addr 2) for 4 cycles.
  - Round-robin build: grants go 0,1,0,1, and the rvalid pulses alternate with the data at addr 1 and addr 2.
  - Fixed-priority build: grants go 0,0,0,0 and port 1 is never granted.
- **Lock:** port 1 does 3 writes, the first two with `m1_lock`=1, while port 0 is continuously valid -> port 0 ready stays 0 for those 3 cycles. Port 0 is granted in the cycle after the unlocked write.
- **Lock abandon:** port 1 transfers with lock=1, then drops `m1_valid` -> FSM returns to OPEN and port 0 is granted one cycle later.
- **Mixed pipeline:** port 0 sequence read 3, write 3←0x11, read 3 -> two rvalid pulses only, with data old value then 0x11. No rvalid for the write.
